// File: rtl/dphy_hs_byte_align.sv
// dphy_hs_byte_align
// Byte aligner for one D-PHY HS data lane. It takes the free-running,
// arbitrarily bit-shifted byte stream from the lane deserializer, looks for the
// HS leader (8 zero bits then sync byte 8'hB8) at any of 8 bit offsets, locks
// to the first offset found and then streams aligned payload bytes.
//
// Optional feature (compile-time macro DPHY_ALIGN_SYNC_TOLERANT_EN):
//   When defined, a sync byte with exactly one bit wrong is also accepted.
//   Exact matches still take priority, and such a lock is flagged on
//   sync_corrected_o. When undefined, only exact sync bytes lock and
//   sync_corrected_o stays 0.
module dphy_hs_byte_align #(
  parameter int SEARCH_TIMEOUT = 255
) (
  input  logic       byte_clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic [7:0] byte_data_i,
  output logic [7:0] byte_data_o,
  output logic       valid_o,
  output logic       sync_found_o,
  output logic       sync_err_o,
  output logic       sync_corrected_o,
  output logic [2:0] bit_offset_o
);

  localparam int CNT_W = $clog2(SEARCH_TIMEOUT + 1);
  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_found;
  logic             w_err;

  logic [7:0]       r_d0;
  logic [7:0]       r_d1;
  logic [7:0]       r_d2;
  logic [23:0]      w_win;

  logic             w_exact_hit;
  logic [2:0]       w_exact_k;
  logic             w_match;
  logic             w_corr;
  logic [2:0]       w_k;
  logic [4:0]       w_pay_lsb;

  // Window bits are oldest at bit 0: the oldest byte d2 sits at the bottom.
  assign w_win     = {r_d0, r_d1, r_d2};
  assign w_pay_lsb = {2'b00, bit_offset_o} + 5'd8;

  // Sliding 3-byte window; forced to all ones outside HS so a zero prefix can
  // only ever come from bits actually received in this burst.
  always_ff @(posedge byte_clk_i) begin
    if (rst_i || !enable_i) begin
      r_d0 <= 8'hFF;
      r_d1 <= 8'hFF;
      r_d2 <= 8'hFF;
    end else begin
      r_d0 <= byte_data_i;
      r_d1 <= r_d0;
      r_d2 <= r_d1;
    end
  end

  // Exact leader search; scanning downward leaves the lowest matching offset.
  always_comb begin
    w_exact_hit = 1'b0;
    w_exact_k   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (w_win[k +: 8] == 8'h00 && w_win[k + 8 +: 8] == SYNC_BYTE) begin
        w_exact_hit = 1'b1;
        w_exact_k   = 3'(k);
      end
    end
  end

`ifdef DPHY_ALIGN_SYNC_TOLERANT_EN
  logic       w_tol_hit;
  logic [2:0] w_tol_k;

  function automatic logic one_bit_off(input logic [7:0] b);
    return ($countones(b ^ SYNC_BYTE) == 1);
  endfunction

  // Single-bit-error sync search, used only when no exact match exists.
  always_comb begin
    w_tol_hit = 1'b0;
    w_tol_k   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (w_win[k +: 8] == 8'h00 && one_bit_off(w_win[k + 8 +: 8])) begin
        w_tol_hit = 1'b1;
        w_tol_k   = 3'(k);
      end
    end
  end

  assign w_match = w_exact_hit || w_tol_hit;
  assign w_k     = w_exact_hit ? w_exact_k : w_tol_k;
  assign w_corr  = !w_exact_hit && w_tol_hit;
`else
  assign w_match = w_exact_hit;
  assign w_k     = w_exact_k;
  assign w_corr  = 1'b0;
`endif

  // State and timeout counter registers.
  always_ff @(posedge byte_clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: a match beats a timeout landing on the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_found     = 1'b0;
    w_err       = 1'b0;
    if (!enable_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt = S_SEARCH;
          w_cnt_nxt   = '0;
        end
        S_SEARCH: begin
          if (w_match) begin
            w_state_nxt = S_LOCKED;
            w_found     = 1'b1;
          end else if (r_cnt == CNT_W'(SEARCH_TIMEOUT)) begin
            w_state_nxt = S_FAIL;
            w_err       = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_LOCKED: w_state_nxt = S_LOCKED;
        S_FAIL:   w_state_nxt = S_FAIL;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Registered outputs: status pulses, held offset and aligned payload byte.
  always_ff @(posedge byte_clk_i) begin
    if (rst_i) begin
      byte_data_o      <= 8'h00;
      valid_o          <= 1'b0;
      sync_found_o     <= 1'b0;
      sync_err_o       <= 1'b0;
      sync_corrected_o <= 1'b0;
      bit_offset_o     <= 3'd0;
    end else begin
      sync_found_o     <= w_found;
      sync_err_o       <= w_err;
      sync_corrected_o <= w_found && w_corr;
      if (w_found) begin
        bit_offset_o <= w_k;
      end
      valid_o <= enable_i && (r_state == S_LOCKED);
      if (enable_i && (r_state == S_LOCKED)) begin
        byte_data_o <= w_win[w_pay_lsb +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dphy_hs_byte_align.sv
// Bench for dphy_hs_byte_align: a cycle table is built up front, a bit-level
// reference model derives every expected lock/data/error event from the
// leader rules, and a monitor compares DUT outputs against that queue.
module tb_dphy_hs_byte_align;

  localparam int T = 255;
  localparam int K_LOCK = 0;
  localparam int K_DATA = 1;
  localparam int K_ERR  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] din;
  logic [7:0] dout;
  logic       vld;
  logic       found;
  logic       err;
  logic       corr;
  logic [2:0] off;

  always #5 clk = ~clk;

  dphy_hs_byte_align #(.SEARCH_TIMEOUT(T)) dut (
    .byte_clk_i      (clk),
    .rst_i           (rst),
    .enable_i        (en),
    .byte_data_i     (din),
    .byte_data_o     (dout),
    .valid_o         (vld),
    .sync_found_o    (found),
    .sync_err_o      (err),
    .sync_corrected_o(corr),
    .bit_offset_o    (off)
  );

  typedef struct {
    int         edge_n;
    int         kind;
    logic [7:0] val;
  } ev_t;

  ev_t        exp_q[$];
  bit         c_en[$];
  bit         c_rst[$];
  logic [7:0] c_dat[$];
  bit         bq[$];

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  bit         last_rst = 1'b0;
  logic [2:0] exp_off = 3'd0;

  // ---------------- stimulus construction ----------------
  task automatic push_cyc(input bit e, input bit r, input logic [7:0] d);
    c_en.push_back(e);
    c_rst.push_back(r);
    c_dat.push_back(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push_cyc(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int j = 0; j < 8; j++) bq.push_back(b[j]);
  endtask

  task automatic add_leader(input int k, input logic [7:0] s);
    for (int i = 0; i < k; i++) bq.push_back(1'b1);
    add_byte(8'h00);
    add_byte(s);
  endtask

  // Pad with ones to a byte boundary and emit the bits as enabled cycles.
  task automatic flush_bits();
    logic [7:0] b;
    while (bq.size() % 8 != 0) bq.push_back(1'b1);
    for (int i = 0; i < bq.size(); i += 8) begin
      for (int j = 0; j < 8; j++) b[j] = bq[i + j];
      push_cyc(1'b1, 1'b0, b);
    end
    bq.delete();
  endtask

  // Bytes that can never contain or form a run of 8 zero bits.
  task automatic add_noise(input int n);
    for (int i = 0; i < n; i++) add_byte(8'($urandom) | 8'h81);
  endtask

  task automatic add_rand(input int n);
    for (int i = 0; i < n; i++) add_byte(8'($urandom));
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] field(input int a, input int p);
    logic [7:0] v;
    logic [7:0] t;
    for (int b = 0; b < 8; b++) begin
      t    = c_dat[a + (p + b) / 8];
      v[b] = t[(p + b) % 8];
    end
    return v;
  endfunction

  // One HS burst of N bytes starting at table index a. With n bytes received
  // the window covers stream bits [8(n-3), 8n); a leader starting at bit p is
  // therefore seen with n = p/8 + 3 bytes in and locks on the following edge.
  task automatic model_burst(input int a, input int nb);
    int s;
    int lock_n;
    int lk;
    bit lc;
    int p;
    ev_t ev;
    s      = a + 1;
    lock_n = -1;
    lk     = 0;
    lc     = 1'b0;
    for (int n = 3; n <= T + 1 && n <= nb - 1 && lock_n < 0; n++) begin
      for (int k = 0; k < 8 && lock_n < 0; k++) begin
        p = 8 * (n - 3) + k;
        if (field(a, p) == 8'h00 && field(a, p + 8) == 8'hB8) begin
          lock_n = n; lk = k; lc = 1'b0;
        end
      end
`ifdef DPHY_ALIGN_SYNC_TOLERANT_EN
      for (int k = 0; k < 8 && lock_n < 0; k++) begin
        p = 8 * (n - 3) + k;
        if (field(a, p) == 8'h00 && $countones(field(a, p + 8) ^ 8'hB8) == 1) begin
          lock_n = n; lk = k; lc = 1'b1;
        end
      end
`endif
    end
    if (lock_n >= 0) begin
      ev.edge_n = s + lock_n;
      ev.kind   = K_LOCK;
      ev.val    = {4'b0000, lc, 3'(lk)};
      exp_q.push_back(ev);
      p = 8 * (lock_n - 3) + lk;
      for (int j = 0; lock_n + 1 + j <= nb - 1; j++) begin
        ev.edge_n = s + lock_n + 1 + j;
        ev.kind   = K_DATA;
        ev.val    = field(a, p + 16 + 8 * j);
        exp_q.push_back(ev);
      end
    end else if (T + 1 <= nb - 1) begin
      ev.edge_n = s + T + 1;
      ev.kind   = K_ERR;
      ev.val    = 8'h00;
      exp_q.push_back(ev);
    end
  endtask

  task automatic build_model();
    int i;
    int b;
    i = 0;
    while (i < c_en.size()) begin
      if (c_en[i] && !c_rst[i]) begin
        b = i;
        while (b + 1 < c_en.size() && c_en[b + 1] && !c_rst[b + 1]) b++;
        model_burst(i, b - i + 1);
        i = b + 1;
      end else begin
        i++;
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    last_rst <= rst;
  end

  task automatic cmp_ev(input int kind, input logic act, input logic [7:0] av, input string nm);
    bit         ex;
    logic [7:0] xv;
    ex = 1'b0;
    xv = 8'h00;
    if (exp_q.size() > 0) begin
      if (exp_q[0].edge_n == cyc && exp_q[0].kind == kind) begin
        ex = 1'b1;
        xv = exp_q[0].val;
      end
    end
    if (act || ex) begin
      checks++;
      if (!(act && ex && av === xv)) begin
        errors++;
        $display("FAIL %s edge=%0d actual present=%0b val=%02h required present=%0b val=%02h",
                 nm, cyc, act, av, ex, xv);
      end
      if (ex) begin
        if (kind == K_LOCK) exp_off = xv[2:0];
        void'(exp_q.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      while (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_event edge=%0d actual none required kind=%0d val=%02h",
                 exp_q[0].edge_n, exp_q[0].kind, exp_q[0].val);
        void'(exp_q.pop_front());
      end
      if (last_rst) begin
        checks++;
        exp_off = 3'd0;
        if ({dout, vld, found, err, corr, off} !== 15'd0) begin
          errors++;
          $display("FAIL reset_outputs edge=%0d actual data=%02h vld=%0b found=%0b err=%0b corr=%0b off=%0d required all 0",
                   cyc, dout, vld, found, err, corr, off);
        end
      end
      cmp_ev(K_LOCK, found, {4'b0000, corr, off}, "sync_found");
      cmp_ev(K_DATA, vld, dout, "payload");
      cmp_ev(K_ERR, err, 8'h00, "sync_err");
      if (corr && !found) begin
        checks++;
        errors++;
        $display("FAIL corrected_alone edge=%0d actual corr=1 found=0 required corr=0", cyc);
      end
      checks++;
      if (off !== exp_off) begin
        errors++;
        $display("FAIL bit_offset edge=%0d actual=%0d required=%0d", cyc, off, exp_off);
      end
    end
  end

  // ---------------- driver ----------------
  initial begin
    // reset, then idle
    for (int i = 0; i < 3; i++) push_cyc(1'b0, 1'b1, 8'h00);
    idle(2);
    // aligned leader, k=0
    add_leader(0, 8'hB8); add_byte(8'h11); add_byte(8'h22); add_byte(8'h33); add_rand(4);
    flush_bits(); idle(2);
    // same stream shifted by 5 bits
    add_leader(5, 8'hB8); add_byte(8'h11); add_byte(8'h22); add_byte(8'h33); add_rand(4);
    flush_bits(); idle(2);
    // no leader for 300 cycles -> timeout, then normal lock after re-enable
    add_noise(300); flush_bits(); idle(1);
    add_leader(0, 8'hB8); add_rand(3); flush_bits(); idle(1);
    // enable dropped mid-payload, immediately followed by a k=3 burst
    add_leader(0, 8'hB8); add_rand(8); flush_bits(); idle(1);
    add_leader(3, 8'hB8); add_rand(4); flush_bits(); idle(2);
    // one-bit-error sync at k=2, long enough to reach the timeout
    add_leader(2, 8'hBC); add_rand(3); add_noise(280); flush_bits(); idle(2);
    // reset pulse while locked, enable held, then a new leader at k=6
    add_leader(0, 8'hB8); add_rand(5); flush_bits();
    push_cyc(1'b1, 1'b1, 8'($urandom));
    add_noise(4); add_leader(6, 8'hB8); add_rand(3); flush_bits(); idle(2);
    // random bursts: random prefix, random offset, random payload length
    for (int r = 0; r < 6; r++) begin
      add_rand($urandom_range(0, 3));
      add_leader($urandom_range(0, 7), 8'hB8);
      add_rand($urandom_range(3, 8));
      flush_bits();
      idle($urandom_range(1, 2));
    end
    idle(2);

    build_model();

    en  = c_en[0];
    rst = c_rst[0];
    din = c_dat[0];
    for (int i = 1; i < c_en.size(); i++) begin
      @(posedge clk);
      #2;
      en  = c_en[i];
      rst = c_rst[i];
      din = c_dat[i];
    end
    @(posedge clk);
    #2;
    en  = 1'b0;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events actual pending=%0d required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
